// File: rtl/raised_pkg.sv
// Shared constants, FSM state type and the pulse-shape table used by the
// raised-cosine transmitter/receiver pair.
package raised_pkg;

  localparam int NSYM   = 20;
  localparam int SPS    = 10;
  localparam int HALF   = SPS / 2;
  localparam int WORD_W = NSYM + 1;
  localparam int DATA_W = 16;
  localparam int ACCW   = 24;
  localparam int THRESH = 70000;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  // One segment of SPS samples per bit pair {first, second}. Head half sums:
  // 0/23888/123432/149320; tail half sums: 0/111855/23888/153536.
  localparam logic signed [DATA_W-1:0] LUT [4][SPS] = '{
    '{16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0,
      16'sd0,     16'sd0,     16'sd0,     16'sd0,     16'sd0},
    '{16'sd1000,  16'sd2500,  16'sd4500,  16'sd6888,  16'sd9000,
      16'sd18000, 16'sd21000, 16'sd23000, 16'sd24500, 16'sd25355},
    '{16'sd30000, 16'sd28000, 16'sd25000, 16'sd22000, 16'sd18432,
      16'sd9000,  16'sd6888,  16'sd4500,  16'sd2500,  16'sd1000},
    '{16'sd31000, 16'sd30500, 16'sd30000, 16'sd29500, 16'sd28320,
      16'sd29000, 16'sd30000, 16'sd31000, 16'sd31500, 16'sd32036}
  };

endpackage

// File: rtl/raised_receiver_if.sv
// Sample-in / word-out handshake bundle between the receiver and its neighbours.
interface raised_receiver_if;
  import raised_pkg::*;

  logic signed [DATA_W-1:0] indata;
  logic                     writeready;
  logic                     waitwrite;
  logic [WORD_W-1:0]        outdata;
  logic                     readready;
  logic                     readack;
  logic                     complete;

  modport slave (
    input  indata, writeready, readack,
    output waitwrite, outdata, readready, complete
  );

  modport master (
    output indata, writeready, readack,
    input  waitwrite, outdata, readready, complete
  );
endinterface

// File: rtl/raised_receiver_half_integrator.sv
// Signed half-segment accumulator; gt_o slices (accumulated + current sample).
module half_integrator
  import raised_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     add_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic                     gt_o
);

  localparam logic signed [ACCW-1:0] THRESH_A = ACCW'(THRESH);

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] sext;
  logic signed [ACCW-1:0] sum;

  assign sext = {{(ACCW-DATA_W){sample_i[DATA_W-1]}}, sample_i};
  assign sum  = acc_q + sext;
  // Decision includes the sample being accepted this cycle.
  assign gt_o = (sum > THRESH_A);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)      acc_d = '0;
    else if (add_i) acc_d = sum;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/raised_receiver.sv
// Raised-cosine receiver: integrates half-segment windows, slices each against
// THRESH and hands the recovered word out on a hold-until-ack port.
module raised_receiver
  import raised_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  raised_receiver_if.slave   bus
);

  localparam int DIGW = $clog2(SPS);
  localparam int SEGW = $clog2(NSYM);
  localparam logic [DIGW-1:0] HALF_D   = DIGW'(HALF);
  localparam logic [DIGW-1:0] HALF_M1  = DIGW'(HALF - 1);
  localparam logic [DIGW-1:0] LAST_D   = DIGW'(SPS - 1);
  localparam logic [SEGW-1:0] LAST_SEG = SEGW'(NSYM - 1);
  localparam logic [SEGW-1:0] NSYM_S   = SEGW'(NSYM);

  state_e              state_q, state_d;
  logic [SEGW-1:0]     seg_q, seg_d;
  logic [DIGW-1:0]     digit_q, digit_d;
  logic [WORD_W-1:1]   bits_q, bits_d;
  logic [WORD_W-1:0]   outdata_q, outdata_d;
  logic                complete_q, complete_d;

  logic accept;
  logic head_clr, head_add, head_gt;
  logic tail_clr, tail_add, tail_gt;

  assign accept   = bus.writeready && (state_q == COLLECT);
  assign head_clr = (state_q == IDLE) || (accept && (digit_q == HALF_M1));
  assign head_add = accept && (digit_q < HALF_D);
  // Only the last segment's second half carries a decision (bit 0).
  assign tail_clr = (state_q == IDLE);
  assign tail_add = accept && (digit_q >= HALF_D) && (seg_q == LAST_SEG);

  half_integrator u_head (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (head_clr),
    .add_i    (head_add),
    .sample_i (bus.indata),
    .gt_o     (head_gt)
  );

  half_integrator u_tail (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tail_clr),
    .add_i    (tail_add),
    .sample_i (bus.indata),
    .gt_o     (tail_gt)
  );

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    digit_d    = digit_q;
    bits_d     = bits_q;
    outdata_d  = outdata_q;
    complete_d = 1'b0;
    case (state_q)
      IDLE: begin
        seg_d   = '0;
        digit_d = '0;
        bits_d  = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        if (accept) begin
          digit_d = digit_q + DIGW'(1);
          // Segment s carries word bits {NSYM-s, NSYM-1-s}; head decides the first.
          if (digit_q == HALF_M1) bits_d[NSYM_S - seg_q] = head_gt;
          if (digit_q == LAST_D) begin
            digit_d = '0;
            if (seg_q != LAST_SEG) begin
              seg_d = seg_q + SEGW'(1);
            end else begin
              outdata_d  = {bits_d, tail_gt};
              complete_d = 1'b1;
              state_d    = DONE;
            end
          end
        end
      end
      DONE: begin
        if (bus.readack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      seg_q      <= '0;
      digit_q    <= '0;
      bits_q     <= '0;
      outdata_q  <= '0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      digit_q    <= digit_d;
      bits_q     <= bits_d;
      outdata_q  <= outdata_d;
      complete_q <= complete_d;
    end
  end

  assign bus.waitwrite = (state_q == COLLECT);
  assign bus.readready = (state_q == DONE);
  assign bus.outdata   = outdata_q;
  assign bus.complete  = complete_q;

endmodule

// File: tb/tb_raised_receiver.sv
// Scoreboard bench for raised_receiver: stimulus pushes expected words, a
// monitor pops and checks them whenever readready rises.
module tb_raised_receiver;
  import raised_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  raised_receiver_if rif();

  raised_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic signed [DATA_W-1:0] sbuf [NSYM*SPS];
  int ack_delay = 0;
  bit ack_hold  = 1'b0;
  bit gap_chk   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fill_word(input logic [WORD_W-1:0] w);
    logic [1:0] p;
    for (int s = 0; s < NSYM; s++) begin
      p = {w[NSYM-s], w[NSYM-1-s]};
      for (int d = 0; d < SPS; d++) sbuf[s*SPS+d] = LUT[p][d];
    end
  endtask

  // Offer n samples from sbuf; writeready asserted with probability duty%.
  task automatic send(input int n, input int duty);
    bit acc;
    int guard;
    for (int i = 0; i < n; i++) begin
      guard = 0;
      do begin
        @(negedge clk);
        rif.indata     = sbuf[i];
        rif.writeready = ($urandom_range(99) < duty);
        acc = rif.writeready && rif.waitwrite;
        guard++;
        if (guard > 2000) begin
          $display("FAIL sample_accept_timeout actual=%0d required=%0d", i, n);
          $fatal(1);
        end
      end while (!acc);
    end
  endtask

  task automatic wait_done(input bit offer);
    int guard = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rif.readready) begin
        rif.writeready = 1'b0;
        break;
      end
      rif.writeready = offer;
      rif.indata     = 16'sh7FFF;
      guard++;
      if (guard > 1000) begin
        checks++;
        errors++;
        $display("FAIL word_timeout actual=%0d required=0", exp_q.size());
        exp_q.delete();
        rif.writeready = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic lb(input logic [WORD_W-1:0] w, input int duty, input bit offer);
    fill_word(w);
    exp_q.push_back(w);
    send(NSYM*SPS, duty);
    wait_done(offer);
  endtask

  initial begin : acker
    int cnt = 0;
    rif.readack = 1'b0;
    forever begin
      @(negedge clk);
      if (rif.readready) begin
        rif.readack = ack_hold || (cnt >= ack_delay);
        cnt++;
      end else begin
        rif.readack = ack_hold;
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    int acc_cnt = 0;
    int rr_len = 0;
    int run0 = 0;
    bit rr_prev = 1'b0;
    bit viol = 1'b0;
    bit saw_done = 1'b0;
    logic [WORD_W-1:0] held = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        acc_cnt = 0; rr_len = 0; run0 = 0;
        rr_prev = 1'b0; viol = 1'b0; saw_done = 1'b0;
        continue;
      end
      if (rif.writeready && rif.waitwrite) acc_cnt++;
      if (rif.readready && rif.waitwrite) viol = 1'b1;
      if (rif.complete && !(rif.readready && !rr_prev)) viol = 1'b1;
      if (rif.readready && !rr_prev) begin
        check("complete_at_rise", rif.complete, 1);
        check("accepts_per_word", acc_cnt, NSYM*SPS);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", rif.outdata);
        end else begin
          check("outdata", rif.outdata, exp_q.pop_front());
        end
        held = rif.outdata;
        acc_cnt = 0;
        rr_len = 1;
        saw_done = 1'b1;
      end else if (rif.readready) begin
        rr_len++;
        if (rif.outdata !== held) viol = 1'b1;
      end else if (rr_prev) begin
        check("readready_len", rr_len, ack_delay + 1);
        check("done_protocol", viol, 0);
        viol = 1'b0;
      end
      if (!rif.waitwrite) begin
        run0++;
      end else begin
        if (gap_chk && saw_done && run0 > 0) check("gap_cycles", run0, 2);
        run0 = 0;
        saw_done = 1'b0;
      end
      rr_prev = rif.readready;
    end
  end

  initial begin : stim
    rif.indata     = '0;
    rif.writeready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_waitwrite", rif.waitwrite, 0);
    check("reset_readready", rif.readready, 0);
    check("reset_complete",  rif.complete,  0);
    check("reset_outdata",   rif.outdata,   0);
    reset = 1'b0;

    lb(21'h000000, 100, 1'b0);
    lb(21'h1FFFFF, 100, 1'b0);
    lb(21'h155555, 100, 1'b0);
    lb(21'h100001, 100, 1'b0);

    // Sparse input and slow consumer; junk is offered while the word is held.
    ack_delay = 7;
    lb(21'h0F0F3C, 30, 1'b1);
    ack_delay = 0;

    // Threshold edges: seg0 head 70000 -> 0, seg1 head 70001 -> 1,
    // seg0 tail large but discarded, seg19 tail exactly 70000 -> 0.
    for (int i = 0; i < NSYM*SPS; i++) sbuf[i] = '0;
    for (int d = 0; d < HALF; d++) begin
      sbuf[d]            = 16'sd14000;
      sbuf[SPS+d]        = 16'sd14000;
      sbuf[HALF+d]       = 16'sd30000;
      sbuf[19*SPS+HALF+d] = 16'sd14000;
    end
    sbuf[SPS+HALF-1] = 16'sd14001;
    exp_q.push_back(21'h080000);
    send(NSYM*SPS, 100);
    wait_done(1'b0);

    // Abort a partial word with reset.
    fill_word(21'h1F00FF);
    send(57, 100);
    @(negedge clk);
    reset = 1'b1;
    rif.writeready = 1'b0;
    @(negedge clk);
    check("midreset_waitwrite", rif.waitwrite, 0);
    check("midreset_readready", rif.readready, 0);
    @(negedge clk);
    reset = 1'b0;
    lb(21'h0ABCDE, 100, 1'b0);

    // Back-to-back words with readack held high.
    ack_hold = 1'b1;
    fill_word(21'h12345A);
    exp_q.push_back(21'h12345A);
    send(NSYM*SPS, 100);
    gap_chk = 1'b1;
    fill_word(21'h0DCBA9);
    exp_q.push_back(21'h0DCBA9);
    send(NSYM*SPS, 100);
    wait_done(1'b0);
    gap_chk  = 1'b0;
    ack_hold = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raised_receiver.md
Name: raised_receiver

Overview:
Receive-side counterpart of the raised-cosine pulse-shaping transmitter. It accepts the 16-bit signed sample stream, which is 20 overlapping bit-pair segments of SPS samples each for one 21-bit word. It integrates half-segment windows and slices them against a threshold to recover the 21-bit word, then presents the word on a hold-until-acknowledged output. It sits after the channel/ADC model and can be wired back-to-back with the transmitter for loopback test.

Parameters:
NSYM, 20, number of bit-pair segments per word; word width is NSYM+1.
SPS, 10, samples per segment; must be even.
HALF, SPS/2, samples per integration window.
THRESH, 70000, signed slicing threshold on a window sum; decision is bit=1 iff sum > THRESH (strict).
ACCW, 24, signed accumulator width; must cover HALF*32767 without overflow.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
indata  input  16  signed sample
writeready  input  1  sample strobe; indata is valid this cycle
waitwrite  output  1  receiver can accept a sample; a sample is accepted iff writeready && waitwrite
outdata  output  NSYM+1  recovered word; MSB is the first bit transmitted
readready  output  1  outdata valid; held until readack
readack  input  1  consumer has taken outdata
complete  output  1  one-cycle pulse when readready rises

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, waitwrite=0, readready=0, complete=0, outdata=0, seg=0, digit=0, both accumulators=0.
- Reset mid-operation: any partial word is discarded and no readready is produced for it.
- States:
  - IDLE: clear seg, digit, acc_head and acc_tail. Go to COLLECT on the next cycle (no start input).
  - COLLECT: waitwrite=1. On each accepted sample:
    - digit < HALF: acc_head += sext(indata).
    - digit >= HALF and seg == NSYM-1: acc_tail += sext(indata).
    - digit >= HALF and seg < NSYM-1: the sample is discarded.
    - digit increments on every accepted sample.
  - Head decision: on the accepted sample with digit == HALF-1, write bit[NSYM-seg] = (acc_head+sample > THRESH), signed compare, and clear acc_head.
  - Segment end: on the accepted sample with digit == SPS-1, set digit=0. If seg < NSYM-1, seg++. Otherwise write bit[0] = (acc_tail+sample > THRESH) and go to DONE.
  - DONE: waitwrite=0, readready=1, outdata=assembled word, complete=1 for the first DONE cycle only. Stay in DONE while readack=0. On readack=1, readready goes to 0 on the next edge and the state returns to IDLE.
- Back-pressure: waitwrite is 1 only in COLLECT, so samples offered in IDLE or DONE are not accepted. writeready gaps of any length in COLLECT only stall the block; no counter advances without an accept.
- Latency: readready and complete are seen high in the cycle after the edge that accepts sample NSYM*SPS (the 200th).
- Minimum gap between words: 2 cycles of waitwrite=0 (DONE, then IDLE), with readack held high.
- Arithmetic: sign-extend indata to ACCW bits. The bit decisions live in a shift/assembly register; outdata is updated only on entry to DONE and is stable while readready=1.
- Expected window sums (transmitter tables):
  - Head window: 00=0, 01=23888, 10=123432, 11=149320.
  - Tail window: 00=0, 01=111855, 10=23888, 11=153536.
  - THRESH sits between the 0-decision group and the 1-decision group for both windows.
- readack while readready=0: ignored.

Decomposition:
- Shared package raised_pkg holds:
  - NSYM, SPS, THRESH;
  - the state enum;
  - the lut/conv coefficient tables, so the transmitter and the bench source one copy.
- Optional sub-module half_integrator: a signed accumulator with clear, add-enable and a compare-to-threshold output. Instantiate it twice (head and tail).

Test Plan:
- Loopback with the transmitter, word 21'h000000: 200 zero samples -> outdata=21'h000000, complete pulses once.
- Loopback, word 21'h1FFFFF -> outdata=21'h1FFFFF. Loopback, word 21'h155555 -> outdata=21'h155555. Loopback, word 21'h100001 -> outdata=21'h100001.
- Back-pressure: writeready random at 30% duty plus readack delayed 7 cycles -> outdata correct. waitwrite=0 for all 7 cycles with readready=1, and no sample is accepted during DONE.
- Threshold boundary: drive head windows summing to exactly 70000 (bit 0) and 70001 (bit 1) for seg 0 and seg 1 -> outdata[20]=0, outdata[19]=1.
- Reset mid-word: assert reset after 57 accepted samples -> the next cycle shows waitwrite=0 and readready=0; the next full word 21'h0ABCDE decodes to 21'h0ABCDE.
- Back-to-back words: readack held high -> exactly 2 cycles with waitwrite=0 between words, and both words are correct.
